// File: rtl/pc_npc_sequencer.sv
// pc_npc_sequencer
//   PC/nPC fetch sequencer implementing the SPARC delayed-branch model.
//   A taken branch is written into nPC so the delay slot at the old nPC
//   still issues. Adds annulled delay slots (squash flag or skip), trap
//   redirect with PC/nPC capture, and a stall hold.
//
// Ports
//   Clk            clock, all state updates on the rising edge
//   Clr            synchronous active-high reset
//   LE             advance enable (0 = stall)
//   Branch_Taken   redirect request for this advance
//   Branch_Target  redirect target address
//   Annul          delay slot of this advance is annulled
//   Trap           trap request (overrides LE, branch and annul)
//   Trap_Vector    trap handler address (not alignment-checked)
//   PC_Out         current fetch address
//   nPC_Out        next fetch address
//   Squash_Out     instruction at PC_Out is annulled (ANNUL_MODE=0 only)
//   Saved_PC       PC captured at the last trap
//   Saved_nPC      nPC captured at the last trap
//   Misaligned_Out one-cycle pulse, a misaligned branch target was dropped
module pc_npc_sequencer #(
  parameter int WIDTH       = 32,
  parameter int RESET_PC    = 0,
  parameter int INSTR_BYTES = 4,
  parameter int ANNUL_MODE  = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             LE,
  input  logic             Branch_Taken,
  input  logic [WIDTH-1:0] Branch_Target,
  input  logic             Annul,
  input  logic             Trap,
  input  logic [WIDTH-1:0] Trap_Vector,
  output logic [WIDTH-1:0] PC_Out,
  output logic [WIDTH-1:0] nPC_Out,
  output logic             Squash_Out,
  output logic [WIDTH-1:0] Saved_PC,
  output logic [WIDTH-1:0] Saved_nPC,
  output logic             Misaligned_Out
);

  localparam logic [WIDTH-1:0] IB        = WIDTH'(INSTR_BYTES);
  localparam logic [WIDTH-1:0] ALIGN_MSK = WIDTH'(INSTR_BYTES - 1);
  localparam logic [WIDTH-1:0] RST_PC    = WIDTH'(RESET_PC);
  localparam logic [WIDTH-1:0] RST_NPC   = RST_PC + IB;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] npc_q, npc_d;
  logic [WIDTH-1:0] spc_q, spc_d;
  logic [WIDTH-1:0] snpc_q, snpc_d;
  logic             squash_q, squash_d;
  logic             mis_q, mis_d;

  logic [WIDTH-1:0] seq;
  logic [WIDTH-1:0] tgt;
  logic             tgt_aligned;

  // IB is a power of two, so alignment reduces to a mask of the low bits.
  assign seq         = npc_q + IB;
  assign tgt_aligned = (Branch_Target & ALIGN_MSK) == '0;
  assign tgt         = (Branch_Taken && tgt_aligned) ? Branch_Target : seq;

  always_comb begin
    pc_d     = pc_q;
    npc_d    = npc_q;
    spc_d    = spc_q;
    snpc_d   = snpc_q;
    squash_d = squash_q;
    mis_d    = 1'b0;
    if (Trap) begin
      spc_d    = pc_q;
      snpc_d   = npc_q;
      pc_d     = Trap_Vector;
      npc_d    = Trap_Vector + IB;
      squash_d = 1'b0;
    end else if (LE) begin
      mis_d = Branch_Taken && !tgt_aligned;
      if (Annul && (ANNUL_MODE != 0)) begin
        // Skip mode: jump straight past the annulled delay slot.
        pc_d     = tgt;
        npc_d    = tgt + IB;
        squash_d = 1'b0;
      end else begin
        pc_d     = npc_q;
        npc_d    = tgt;
        squash_d = Annul;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Clr) begin
      pc_q     <= RST_PC;
      npc_q    <= RST_NPC;
      spc_q    <= '0;
      snpc_q   <= '0;
      squash_q <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      npc_q    <= npc_d;
      spc_q    <= spc_d;
      snpc_q   <= snpc_d;
      squash_q <= squash_d;
      mis_q    <= mis_d;
    end
  end

  assign PC_Out         = pc_q;
  assign nPC_Out        = npc_q;
  assign Squash_Out     = squash_q;
  assign Saved_PC       = spc_q;
  assign Saved_nPC      = snpc_q;
  assign Misaligned_Out = mis_q;

endmodule

// File: doc/pc_npc_sequencer.md
Name: pc_npc_sequencer

Overview:
- Parametrised PC/nPC fetch sequencer for the SPARC pipeline; it replaces the fixed 32-bit PC and nPC register pair and the +4 adder.
- Implements the delayed-branch model: a branch redirect is written into nPC, so the delay slot at the old nPC still issues.
- Adds three features: annulled delay slots (squash mode or skip mode), trap redirect that saves PC/nPC, and a stall hold.
- Outputs feed the instruction ROM address and the IF/ID pipeline register.

Parameters:
- WIDTH, 32, address width in bits.
- RESET_PC, 0, PC value after reset; nPC resets to RESET_PC+INSTR_BYTES.
- INSTR_BYTES, 4, instruction size in bytes; must be a power of two, at least 1.
- ANNUL_MODE, 0, 0 = fetch the delay slot and flag it via Squash_Out; 1 = skip the delay slot by redirecting PC directly.

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- Clr  in  1  reset, synchronous, active-high.
- LE  in  1  advance enable; 0 = stall (hold PC, nPC, Squash_Out).
- Branch_Taken  in  1  redirect request for this advance.
- Branch_Target  in  WIDTH  redirect target address.
- Annul  in  1  delay slot of this advance is annulled; already resolved by the control unit.
- Trap  in  1  trap request.
- Trap_Vector  in  WIDTH  trap handler address.
- PC_Out  out  WIDTH  current fetch address.
- nPC_Out  out  WIDTH  next fetch address.
- Squash_Out  out  1  instruction at PC_Out is annulled (ANNUL_MODE=0 only).
- Saved_PC  out  WIDTH  PC captured at the last trap.
- Saved_nPC  out  WIDTH  nPC captured at the last trap.
- Misaligned_Out  out  1  one-cycle pulse: misaligned target was rejected.

Behaviour:
- All outputs are registered; there is no combinational path from inputs to outputs.
- All additions are modulo 2^WIDTH. Wrap-around from the top address to 0 is legal and is not flagged.
- Notation: IB = INSTR_BYTES, seq = nPC+IB.
- Aligned means (address mod IB) == 0.
- T = Branch_Target if (Branch_Taken and Branch_Target is aligned), else seq.
- Reset (Clr=1), highest priority:
  - PC=RESET_PC, nPC=RESET_PC+IB.
  - Squash_Out=0, Saved_PC=0, Saved_nPC=0, Misaligned_Out=0.
- Trap (Clr=0, Trap=1), overrides LE=0, branch and annul inputs:
  - Saved_PC<=PC, Saved_nPC<=nPC.
  - PC<=Trap_Vector, nPC<=Trap_Vector+IB.
  - Squash_Out<=0.
  - Trap_Vector is not alignment-checked.
- Stall (Clr=0, Trap=0, LE=0):
  - All registers hold.
  - Misaligned_Out<=0.
  - Branch and annul inputs are ignored and not remembered.
- Advance (Clr=0, Trap=0, LE=1, Annul=0):
  - PC<=nPC, nPC<=T, Squash_Out<=0.
- Advance with Annul=1, ANNUL_MODE=0:
  - PC<=nPC, nPC<=T, Squash_Out<=1.
- Advance with Annul=1, ANNUL_MODE=1:
  - PC<=T, nPC<=T+IB, Squash_Out<=0; the delay slot is never fetched.
- Misalignment:
  - Condition: Branch_Taken=1, Branch_Target not aligned, on an advance cycle.
  - Redirect is dropped and the sequential path is used.
  - Misaligned_Out<=1 for exactly one cycle; otherwise Misaligned_Out<=0 on every non-reset edge.
- Branch_Taken=0 with Annul=1 is legal (the untaken annulling branch).
- Saved_PC and Saved_nPC change only on a trap or a reset.
- Back-to-back traps: each trap overwrites Saved_* with the PC/nPC current at that edge.

Test Plan:
- Reset, then 3 advances, defaults: after Clr, PC=0, nPC=4. After the advances, PC=C, nPC=10 (hex), Squash_Out=0 throughout.
- Delayed branch:
  - Start PC=8, nPC=C.
  - Advance with Branch_Taken=1, Branch_Target=40: PC=C, nPC=40.
  - Next advance: PC=40, nPC=44.
- Annul, ANNUL_MODE=0:
  - Start PC=8, nPC=C.
  - Advance with Taken=1, Annul=1, target 40: PC=C, nPC=40, Squash_Out=1.
  - Next plain advance: Squash_Out=0.
  - Same stimulus with ANNUL_MODE=1: PC=40, nPC=44, Squash_Out=0.
- Stall and trap:
  - Hold LE=0 for 3 cycles: PC/nPC unchanged, branch inputs ignored.
  - Trap=1 with LE=0, Trap_Vector=200, from PC=20, nPC=24: PC=200, nPC=204, Saved_PC=20, Saved_nPC=24.
- Misaligned target:
  - Start PC=8, nPC=C; advance with Taken=1, Branch_Target=42.
  - Result: PC=C, nPC=10, Misaligned_Out=1 for one cycle, then 0.
- Wrap and reset mid-run:
  - Start nPC=FFFFFFFC; advance: PC=FFFFFFFC, nPC=0.
  - Clr asserted together with Trap=1: reset values win, Saved_*=0.
